// File: rtl/skynet_mul_pkg.sv
// skynet_mul_pkg: shared constants and shift/saturate helpers for the multiply pipeline
package skynet_mul_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 4;
    localparam int SHIFT_MIN     = 0;
    localparam int MAX_W         = 128;

    typedef logic [MAX_W-1:0] wide_t;

    function automatic int shift_max(input int a_w, input int b_w);
        return a_w + b_w - 1;
    endfunction

    function automatic bit result_signed(input int sa, input int sb);
        return (sa != 0) || (sb != 0);
    endfunction

    function automatic wide_t shift_right(input wide_t v, input int sh, input bit sgn);
        if (sgn) return $signed(v) >>> sh;
        return v >> sh;
    endfunction

    function automatic wide_t sat_hi(input int w, input bit sgn);
        return (wide_t'(1) << (sgn ? w - 1 : w)) - 1;
    endfunction

    function automatic bit clipped(input wide_t v, input int w, input bit sgn);
        return sgn ? ($signed(v) > $signed(sat_hi(w, sgn)) || $signed(v) < $signed(~sat_hi(w, sgn)))
                   : (v > sat_hi(w, sgn));
    endfunction

    // the signed lower bound is the bitwise complement of the upper bound
    function automatic wide_t saturate(input wide_t v, input int w, input bit sgn);
        if (!clipped(v, w, sgn)) return v;
        return (sgn && v[MAX_W-1]) ? ~sat_hi(w, sgn) : sat_hi(w, sgn);
    endfunction

endpackage

// File: rtl/skynet_mul_sat.sv
// skynet_mul_sat: combinational right shift followed by saturation to the output width
module skynet_mul_sat
    import skynet_mul_pkg::*;
#(
    parameter int IN_W       = 24,
    parameter int OUT_W      = 19,
    parameter int SHIFT      = 0,
    parameter bit RES_SIGNED = 1'b0
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);

    wide_t shifted;

    // extend to the helper width per signedness, then shift
    always_comb shifted = shift_right({{(MAX_W-IN_W){RES_SIGNED & din[IN_W-1]}}, din}, SHIFT, RES_SIGNED);

    // clip into the output range and flag when clipping happened
    always_comb begin
        dout = OUT_W'(saturate(shifted, OUT_W, RES_SIGNED));
        sat  = clipped(shifted, OUT_W, RES_SIGNED);
    end

endmodule

// File: rtl/skynet_mul_pipe.sv
// skynet_mul_pipe: pipelined multiplier with optional accumulate, shift and saturation
module skynet_mul_pipe
    import skynet_mul_pkg::*;
#(
    parameter int A_W       = 7,
    parameter int B_W       = 13,
    parameter int OUT_W     = 19,
    parameter int NUM_STAGE = 3,
    parameter int SIGNED_A  = 0,
    parameter int SIGNED_B  = 0,
    parameter int SHIFT     = 0,
    parameter int ACC_GUARD = 4
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    input  logic             acc_en,
    input  logic             acc_first,
    output logic [OUT_W-1:0] dout,
    output logic             out_valid,
    output logic             sat
);

    localparam int PW = A_W + B_W;
    localparam int AW = PW + ACC_GUARD;
    localparam bit RS = result_signed(SIGNED_A, SIGNED_B);

    typedef struct packed {
        logic          v;
        logic          en;
        logic          first;
        logic [PW-1:0] p;
    } stage_t;

    stage_t           s_in, s_fin;
    logic [AW-1:0]    acc, acc_nxt, p_ext, src;
    logic [OUT_W-1:0] sat_dout;
    logic             sat_flag;

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX ||
        SHIFT < SHIFT_MIN || SHIFT > shift_max(A_W, B_W)) begin : g_bad_param
        $error("skynet_mul_pipe: NUM_STAGE or SHIFT out of range");
    end

    // extend each operand per its own signedness; the low PW bits of the product are exact
    always_comb begin
        s_in.v     = in_valid;
        s_in.en    = acc_en;
        s_in.first = acc_first;
        s_in.p     = {{(PW-A_W){SIGNED_A != 0 && din0[A_W-1]}}, din0}
                   * {{(PW-B_W){SIGNED_B != 0 && din1[B_W-1]}}, din1};
    end

    if (NUM_STAGE == 1) begin : g_direct
        assign s_fin = s_in;
    end else begin : g_pipe
        stage_t pipe [NUM_STAGE-1];
        // retiming registers behind the multiplier, shifted only when enabled
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                for (int i = 0; i < NUM_STAGE-1; i++) pipe[i] <= '0;
            end else if (ce) begin
                pipe[0] <= s_in;
                for (int i = 1; i < NUM_STAGE-1; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign s_fin = pipe[NUM_STAGE-2];
    end

    // accumulator update candidate and result source selection
    always_comb begin
        p_ext   = {{ACC_GUARD{RS & s_fin.p[PW-1]}}, s_fin.p};
        acc_nxt = s_fin.first ? p_ext : acc + p_ext;
        src     = s_fin.en ? acc_nxt : p_ext;
    end

    skynet_mul_sat #(
        .IN_W      (AW),
        .OUT_W     (OUT_W),
        .SHIFT     (SHIFT),
        .RES_SIGNED(RS)
    ) u_sat (
        .din (src),
        .dout(sat_dout),
        .sat (sat_flag)
    );

    // final stage: results and accumulator only move on valid slots
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            sat       <= 1'b0;
        end else if (ce) begin
            out_valid <= s_fin.v;
            if (s_fin.v) begin
                dout <= sat_dout;
                sat  <= sat_flag;
                if (s_fin.en) acc <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_skynet_mul_pipe.sv
// tb_skynet_mul_pipe: scoreboard bench for an unsigned and a signed/shifted instance
module tb_skynet_mul_pipe;

    logic        ap_clk = 1'b0, ap_rst_n = 1'b1;
    logic        ce = 1'b0, in_valid = 1'b0, acc_en = 1'b0, acc_first = 1'b0;
    logic [6:0]  din0 = '0;
    logic [12:0] din1 = '0;
    logic [19:0] u_dout;
    logic [15:0] s_dout;
    logic        u_ov, u_sat, s_ov, s_sat;

    typedef struct {
        longint d;
        bit     s;
        int     issue;
    } exp_t;

    exp_t   qu[$], qs[$];
    int     checks = 0, errors = 0, ecyc = 0;
    bit     en_edge = 1'b0;
    longint u_acc = 0, s_acc = 0;
    longint lu_d = 0, ls_d = 0;
    bit     lu_s = 1'b0, ls_s = 1'b0, lu_ov = 1'b0, ls_ov = 1'b0;

    always #5 ap_clk = ~ap_clk;

    skynet_mul_pipe #(.OUT_W(20)) u_dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .acc_en(acc_en), .acc_first(acc_first),
        .dout(u_dout), .out_valid(u_ov), .sat(u_sat)
    );

    skynet_mul_pipe #(.OUT_W(16), .SIGNED_A(1), .SHIFT(3)) s_dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .acc_en(acc_en), .acc_first(acc_first),
        .dout(s_dout), .out_valid(s_ov), .sat(s_sat)
    );

    task automatic chk(input string n, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", n, got, want);
        end
    endtask

    // true-integer product, 24-bit wrapping accumulator, floor shift, clip to range
    function automatic void model(input logic [6:0] a, input logic [12:0] b, input bit en, first, sa,
                                  input int sh, ow, inout longint acc, output exp_t e);
        longint p, src, hi, lo;
        p = (sa ? longint'($signed(a)) : longint'(a)) * longint'(b);
        if (en) begin
            acc = first ? p : acc + p;
            acc = acc & ((longint'(1) << 24) - 1);
            if (sa && acc >= (longint'(1) << 23)) acc -= longint'(1) << 24;
        end
        src = (en ? acc : p) >>> sh;
        hi = sa ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
        lo = sa ? -(longint'(1) << (ow - 1)) : 0;
        e.s = (src > hi) || (src < lo);
        e.d = (src > hi) ? hi : (src < lo) ? lo : src;
        e.issue = ecyc;
    endfunction

    task automatic step(input bit c, v, input logic [6:0] a, input logic [12:0] b, input bit en, first);
        exp_t e;
        ce = c; in_valid = v; din0 = a; din1 = b; acc_en = en; acc_first = first;
        @(posedge ap_clk);
        en_edge = ce && ap_rst_n;
        if (en_edge) begin
            if (v) begin
                model(a, b, en, first, 1'b0, 0, 20, u_acc, e);
                qu.push_back(e);
                model(a, b, en, first, 1'b1, 3, 16, s_acc, e);
                qs.push_back(e);
            end
            ecyc++;
        end
        @(negedge ap_clk);
    endtask

    // unsigned instance: a result is due exactly three enabled edges after issue, else outputs hold
    always @(negedge ap_clk) begin : mon_u
        exp_t e;
        bit   xo;
        e = '{lu_d, lu_s, 0};
        xo = lu_ov;
        if (!ap_rst_n) begin
            e = '{0, 1'b0, 0};
            xo = 1'b0;
        end else begin
            if (en_edge) begin
                xo = qu.size() > 0 && qu[0].issue == ecyc - 3;
                if (xo) e = qu.pop_front();
            end
            chk("u_valid", u_ov, xo);
            chk("u_dout", u_dout, e.d & 20'hFFFFF);
            chk("u_sat", u_sat, e.s);
        end
        lu_ov <= xo;
        lu_d <= e.d;
        lu_s <= e.s;
    end

    // signed, shifted instance: same schedule, own expectations
    always @(negedge ap_clk) begin : mon_s
        exp_t e;
        bit   xo;
        e = '{ls_d, ls_s, 0};
        xo = ls_ov;
        if (!ap_rst_n) begin
            e = '{0, 1'b0, 0};
            xo = 1'b0;
        end else begin
            if (en_edge) begin
                xo = qs.size() > 0 && qs[0].issue == ecyc - 3;
                if (xo) e = qs.pop_front();
            end
            chk("s_valid", s_ov, xo);
            chk("s_dout", s_dout, e.d & 16'hFFFF);
            chk("s_sat", s_sat, e.s);
        end
        ls_ov <= xo;
        ls_d <= e.d;
        ls_s <= e.s;
    end

    initial begin
        #1 ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        chk("rst_u_valid", u_ov, 0);
        chk("rst_u_dout", u_dout, 0);
        chk("rst_u_sat", u_sat, 0);
        chk("rst_s_valid", s_ov, 0);
        chk("rst_s_dout", s_dout, 0);
        chk("rst_s_sat", s_sat, 0);
        #2 ap_rst_n = 1'b1;
        step(1, 1, 7'd3, 13'd7, 1, 0);
        step(1, 1, 7'd127, 13'd8191, 0, 0);
        step(1, 1, 7'd64, 13'd4095, 0, 0);
        step(1, 1, 7'd64, 13'd8191, 0, 0);
        step(1, 0, 7'd0, 13'd0, 0, 0);
        step(1, 1, 7'd2, 13'd3, 1, 1);
        step(1, 1, 7'd4, 13'd5, 1, 0);
        step(1, 1, 7'd1, 13'd1, 1, 0);
        step(1, 1, 7'd10, 13'd20, 0, 0);
        step(1, 1, 7'd11, 13'd21, 0, 0);
        repeat (5) step(0, 1'($urandom), 7'($urandom), 13'($urandom), 1'($urandom), 1'($urandom));
        repeat (4) step(1, 0, 7'd0, 13'd0, 0, 0);
        repeat (400) step($urandom_range(0, 7) != 0, 1'($urandom), 7'($urandom), 13'($urandom),
                          1'($urandom), $urandom_range(0, 3) == 0);
        repeat (5) step(1, 0, 7'd0, 13'd0, 0, 0);
        step(1, 1, 7'd100, 13'd100, 0, 0);
        step(1, 1, 7'd90, 13'd99, 0, 0);
        step(1, 1, 7'd80, 13'd98, 1, 1);
        step(1, 1, 7'd70, 13'd97, 1, 0);
        ce = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1;
        chk("arst_u_valid", u_ov, 0);
        chk("arst_u_dout", u_dout, 0);
        chk("arst_s_valid", s_ov, 0);
        chk("arst_s_dout", s_dout, 0);
        qu.delete();
        qs.delete();
        u_acc = 0;
        s_acc = 0;
        @(negedge ap_clk);
        #2 ap_rst_n = 1'b1;
        step(1, 1, 7'd5, 13'd6, 1, 0);
        repeat (100) step($urandom_range(0, 7) != 0, 1'($urandom), 7'($urandom), 13'($urandom),
                          1'($urandom), $urandom_range(0, 3) == 0);
        repeat (5) step(1, 0, 7'd0, 13'd0, 0, 0);
        chk("u_drain", qu.size(), 0);
        chk("s_drain", qs.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
